// File: rtl/rf_write_serializer.sv
// rf_write_serializer: buffers up to NR_WR register-file write-backs per cycle
// in an in-order queue, drains one entry per cycle onto the single RAM write
// port, and forwards pending data to the three asynchronous read ports.
module rf_write_serializer #(
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned NR_WR       = 2,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic                                  Clk_CI,
   input  logic                                  Rst_RBI,
   input  logic [NR_WR-1:0]                      WrEn_SI,
   input  logic [NR_WR-1:0][ADDR_WIDTH-1:0]      WrAddr_DI,
   input  logic [NR_WR-1:0][DATA_WIDTH-1:0]      WrData_DI,
   output logic                                  WrReady_SO,
   output logic                                  RamWrEn_SO,
   output logic [ADDR_WIDTH-1:0]                 RamWrAddr_DO,
   output logic [DATA_WIDTH-1:0]                 RamWrData_DO,
   input  logic [ADDR_WIDTH-1:0]                 RdAddr_DI_0,
   input  logic [ADDR_WIDTH-1:0]                 RdAddr_DI_1,
   input  logic [ADDR_WIDTH-1:0]                 RdAddr_DI_2,
   input  logic [DATA_WIDTH-1:0]                 RamRdData_DI_0,
   input  logic [DATA_WIDTH-1:0]                 RamRdData_DI_1,
   input  logic [DATA_WIDTH-1:0]                 RamRdData_DI_2,
   output logic [DATA_WIDTH-1:0]                 RdData_DO_0,
   output logic [DATA_WIDTH-1:0]                 RdData_DO_1,
   output logic [DATA_WIDTH-1:0]                 RdData_DO_2,
   output logic                                  Busy_SO
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

   logic [ADDR_WIDTH-1:0] r_addr [QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0] r_data [QUEUE_DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;

   logic                  w_ready;
   logic                  w_pop;
   logic [NR_WR-1:0]      w_acc;
   logic [CNT_W-1:0]      w_nenq;
   logic [PTR_W-1:0]      w_slot [NR_WR];

   // Ready uses the registered count only; a same-cycle pop is not credited.
   assign w_ready    = (QUEUE_DEPTH - 32'(r_count)) >= NR_WR;
   assign w_acc      = w_ready ? WrEn_SI : '0;
   assign w_pop      = (r_count != '0);
   assign WrReady_SO = w_ready;
   assign Busy_SO    = w_pop;

   // Pack accepted requests densely behind the tail, in port order.
   always_comb begin
      w_nenq = '0;
      for (int unsigned i = 0; i < NR_WR; i++) begin
         w_slot[i] = r_tail + PTR_W'(w_nenq);
         if (w_acc[i]) w_nenq = w_nenq + CNT_W'(1);
      end
   end

   // Pointer and occupancy bookkeeping; power-of-two depth makes wrap implicit.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) r_head <= r_head + PTR_W'(1);
         r_tail  <= r_tail + PTR_W'(w_nenq);
         r_count <= r_count + w_nenq - CNT_W'(w_pop);
      end
   end

   // Queue entry storage, written at the slots computed above.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         for (int unsigned j = 0; j < QUEUE_DEPTH; j++) begin
            r_addr[j] <= '0;
            r_data[j] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NR_WR; i++) begin
            if (w_acc[i]) begin
               r_addr[w_slot[i]] <= WrAddr_DI[i];
               r_data[w_slot[i]] <= WrData_DI[i];
            end
         end
      end
   end

   // Head entry drives the RAM write port; zeros when the queue is empty.
   always_comb begin
      RamWrEn_SO   = w_pop;
      RamWrAddr_DO = '0;
      RamWrData_DO = '0;
      if (w_pop) begin
         RamWrAddr_DO = r_addr[r_head];
         RamWrData_DO = r_data[r_head];
      end
   end

   // Scan oldest to youngest so the youngest matching entry wins.
   function automatic logic [DATA_WIDTH-1:0] f_fwd(
      input logic [ADDR_WIDTH-1:0] i_addr,
      input logic [DATA_WIDTH-1:0] i_ram
   );
      logic [PTR_W-1:0] w_idx;
      f_fwd = i_ram;
      for (int unsigned j = 0; j < QUEUE_DEPTH; j++) begin
         w_idx = r_head + PTR_W'(j);
         if ((j < 32'(r_count)) && (r_addr[w_idx] == i_addr)) f_fwd = r_data[w_idx];
      end
   endfunction

   // Read forwarding for the three consumer ports.
   always_comb begin
      RdData_DO_0 = f_fwd(RdAddr_DI_0, RamRdData_DI_0);
      RdData_DO_1 = f_fwd(RdAddr_DI_1, RamRdData_DI_1);
      RdData_DO_2 = f_fwd(RdAddr_DI_2, RamRdData_DI_2);
   end

`ifndef SYNTHESIS
   // Simulation-only sanity checks on configuration and handshake.
   always @(posedge Clk_CI) begin
      if (Rst_RBI) begin
         assert (QUEUE_DEPTH >= NR_WR)
            else $error("QUEUE_DEPTH smaller than NR_WR");
         assert ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) == 0)
            else $error("QUEUE_DEPTH not a power of two");
         assert (!((|WrEn_SI) && !w_ready))
            else $error("write request while WrReady_SO low, request dropped");
         assert (32'(r_count) <= QUEUE_DEPTH)
            else $error("queue count exceeds depth");
      end
   end
`endif

endmodule

// File: tb/tb_rf_write_serializer.sv
// tb_rf_write_serializer: directed and random traffic against a reference of
// an immediately-written RAM plus an in-order pending-write list.
module tb_rf_write_serializer;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int NW = 2;
   localparam int QD = 4;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NW-1:0]           wr_en;
   logic [NW-1:0][AW-1:0]   wr_addr;
   logic [NW-1:0][DW-1:0]   wr_data;
   logic                    wr_ready, ram_we, busy;
   logic [AW-1:0]           ram_wa;
   logic [DW-1:0]           ram_wd;
   logic [AW-1:0]           rd_a0, rd_a1, rd_a2;
   logic [DW-1:0]           ram_rd0, ram_rd1, ram_rd2;
   logic [DW-1:0]           rd_d0, rd_d1, rd_d2;

   // Environment RAM: asynchronous read, written on the rising edge.
   logic [DW-1:0] ram [32] = '{default: '0};

   // Reference state.
   logic [DW-1:0] golden [32];
   logic [DW-1:0] commit [32];
   ent_t          q [$];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_we) ram[ram_wa] <= ram_wd;

   assign ram_rd0 = ram[rd_a0];
   assign ram_rd1 = ram[rd_a1];
   assign ram_rd2 = ram[rd_a2];

   rf_write_serializer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NR_WR      (NW),
      .QUEUE_DEPTH(QD)
   ) dut (
      .Clk_CI        (clk),
      .Rst_RBI       (rst_n),
      .WrEn_SI       (wr_en),
      .WrAddr_DI     (wr_addr),
      .WrData_DI     (wr_data),
      .WrReady_SO    (wr_ready),
      .RamWrEn_SO    (ram_we),
      .RamWrAddr_DO  (ram_wa),
      .RamWrData_DO  (ram_wd),
      .RdAddr_DI_0   (rd_a0),
      .RdAddr_DI_1   (rd_a1),
      .RdAddr_DI_2   (rd_a2),
      .RamRdData_DI_0(ram_rd0),
      .RamRdData_DI_1(ram_rd1),
      .RamRdData_DI_2(ram_rd2),
      .RdData_DO_0   (rd_d0),
      .RdData_DO_1   (rd_d1),
      .RdData_DO_2   (rd_d2),
      .Busy_SO       (busy)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic check_outputs(input logic rdy);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = '0;
      ed = '0;
      if (q.size() != 0) begin
         ea = q[0].a;
         ed = q[0].d;
      end
      chk("ram_we",   DW'(ram_we),   DW'(q.size() != 0));
      chk("ram_addr", DW'(ram_wa),   DW'(ea));
      chk("ram_data", ram_wd,        ed);
      chk("busy",     DW'(busy),     DW'(q.size() != 0));
      chk("wr_ready", DW'(wr_ready), DW'(rdy));
      chk("rd0",      rd_d0,         golden[rd_a0]);
      chk("rd1",      rd_d1,         golden[rd_a1]);
      chk("rd2",      rd_d2,         golden[rd_a2]);
   endtask

   // One clock cycle: drive, check combinational outputs, then advance the model.
   task automatic step(input logic [NW-1:0] want,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, output logic acc);
      logic rdy;
      ent_t e;
      @(negedge clk);
      rdy        = (QD - q.size()) >= NW;
      acc        = rdy;
      wr_en      = rdy ? want : '0;
      wr_addr[0] = a0;
      wr_data[0] = d0;
      wr_addr[1] = a1;
      wr_data[1] = d1;
      rd_a0      = r0;
      rd_a1      = r1;
      rd_a2      = r2;
      #1;
      check_outputs(rdy);
      @(posedge clk);
      if (q.size() != 0) begin
         e = q.pop_front();
         commit[e.a] = e.d;
      end
      for (int i = 0; i < NW; i++) begin
         if (wr_en[i]) begin
            e.a = wr_addr[i];
            e.d = wr_data[i];
            q.push_back(e);
            golden[e.a] = e.d;
         end
      end
   endtask

   task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      logic acc;
      step('0, '0, '0, '0, '0, r0, r1, r2, acc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   guard;
      for (int i = 0; i < 32; i++) begin
         golden[i] = '0;
         commit[i] = '0;
      end
      rst_n   = 1'b0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_a0   = '0;
      rd_a1   = '0;
      rd_a2   = '0;
      #12;
      chk("rst_ram_we",   DW'(ram_we),   '0);
      chk("rst_ram_addr", DW'(ram_wa),   '0);
      chk("rst_ram_data", ram_wd,        '0);
      chk("rst_busy",     DW'(busy),     '0);
      chk("rst_wr_ready", DW'(wr_ready), DW'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Single write on port 0, read back through forwarding next cycle.
      step(2'b01, 5'd3, 64'hAA, '0, '0, 5'd3, '0, '0, acc);
      idle(5'd3, '0, '0);
      idle(5'd3, '0, '0);
      chk("t1_ram3", ram[3], 64'hAA);

      // Back-to-back pairs 1..8 with backpressure.
      for (int p = 0; p < 4; p++) begin
         guard = 0;
         do begin
            step(2'b11, AW'(2*p+1), DW'(64'h100 + 2*p + 1), AW'(2*p+2), DW'(64'h100 + 2*p + 2),
                 AW'(2*p+1), AW'(2*p+2), 5'd3, acc);
            guard++;
         end while (!acc && guard < 10);
         chk("t2_accept", DW'(acc), DW'(1));
      end
      for (int i = 0; i < 6; i++) idle(5'd1, 5'd8, 5'd5);

      // Same address on both ports: higher port wins.
      step(2'b11, 5'd5, 64'h11, 5'd5, 64'h22, 5'd5, 5'd5, 5'd5, acc);
      idle(5'd5, '0, '0);
      idle(5'd5, '0, '0);
      idle(5'd5, '0, '0);
      chk("t3_ram5", ram[5], 64'h22);

      // Two pending entries for addr 7; port 1 reads a non-pending address.
      step(2'b01, 5'd9, 64'h99, '0, '0, '0, '0, '0, acc);
      idle('0, 5'd9, '0);
      idle('0, 5'd9, '0);
      step(2'b11, 5'd7, 64'h01, 5'd7, 64'h02, '0, 5'd9, 5'd7, acc);
      idle('0, 5'd9, 5'd7);
      idle('0, 5'd9, 5'd7);
      idle('0, 5'd9, 5'd7);

      // Reset with three entries pending.
      step(2'b11, 5'd10, 64'hA0, 5'd11, 64'hA1, 5'd10, 5'd11, 5'd12, acc);
      step(2'b11, 5'd12, 64'hA2, 5'd13, 64'hA3, 5'd10, 5'd11, 5'd12, acc);
      @(negedge clk);
      wr_en = '0;
      #1;
      chk("t5_busy_before", DW'(busy), DW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_ram_we",   DW'(ram_we),   '0);
      chk("t5_busy",     DW'(busy),     '0);
      chk("t5_wr_ready", DW'(wr_ready), DW'(1));
      q.delete();
      for (int i = 0; i < 32; i++) golden[i] = commit[i];
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) idle(5'd11, 5'd12, 5'd13);

      // Random traffic over a small address range to force hits and wrap.
      for (int n = 0; n < 400; n++) begin
         step(NW'($urandom_range(0, 3)),
              AW'($urandom_range(0, 7)), {$urandom, $urandom},
              AW'($urandom_range(0, 7)), {$urandom, $urandom},
              AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)),
              AW'($urandom_range(0, 13)), acc);
      end
      guard = 0;
      while (q.size() != 0 && guard < 10) begin
         idle(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
         guard++;
      end
      idle('0, '0, '0);
      for (int i = 0; i < 32; i++) chk($sformatf("final_ram%0d", i), ram[i], golden[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
